ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/yarc_pkg.sv | 45 ++++
 rtl/wait_timer.sv | 34 +++
 rtl/ctrl_seq.sv | 176 +++++++++++++++++
 tb/tb_ctrl_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/yarc_pkg.sv
// rtl/yarc_pkg.sv - shared encodings for the ctrl_seq control sequencer
// Holds the state encoding, wb_sel/pc_sel/trap_cause codes, the instype
// one-hot bit positions, the default wait timeout and a one-hot helper.
package yarc_pkg;

    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam int IT_W      = 9;
    localparam int IT_REG    = 0;
    localparam int IT_IMM    = 1;
    localparam int IT_STORE  = 2;
    localparam int IT_LOAD   = 3;
    localparam int IT_BRANCH = 4;
    localparam int IT_LUI    = 5;
    localparam int IT_AUIPC  = 6;
    localparam int IT_JAL    = 7;
    localparam int IT_JALR   = 8;

    function automatic logic is_onehot(input logic [IT_W-1:0] v);
        return (v != '0) && ((v & (v - 9'd1)) == '0);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - wait-cycle counter flagging the last allowed wait cycle
// Ports: i_clk, i_rst (async, active-high), i_clear (zero the count),
//        i_enable (count this cycle), o_done (this is wait cycle TIMEOUT).
import yarc_pkg::*;

module wait_timer #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Asserted during the cycle whose missing ack would bring the count to TIMEOUT.
    assign o_done = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multi-cycle instruction control sequencer with traps
// Ports: i_clk, i_rst (async, active-high); fetch o_imem_req/i_imem_ack/o_ir_load;
//        decode i_instype (one-hot), i_ren, i_wen, i_br_taken; data
//        o_dmem_req/o_dmem_we/i_dmem_ack; writeback o_rf_wen/o_wb_sel;
//        PC o_pc_load/o_pc_sel; status o_trap/o_trap_cause/o_state.
import yarc_pkg::*;

module ctrl_seq #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    input  logic            i_imem_ack,
    output logic            o_ir_load,
    input  logic [IT_W-1:0] i_instype,
    input  logic            i_ren,
    input  logic            i_wen,
    input  logic            i_br_taken,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    input  logic            i_dmem_ack,
    output logic            o_rf_wen,
    output logic [1:0]      o_wb_sel,
    output logic            o_pc_load,
    output logic [1:0]      o_pc_sel,
    output logic            o_trap,
    output logic [1:0]      o_trap_cause,
    output logic [2:0]      o_state
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cause;
    logic [1:0] w_cause;
    // Class flags captured in EXEC so MEM/WB do not depend on the decoder holding its output.
    logic       r_load;
    logic       r_we;
    logic       r_lui;
    logic       r_jal;
    logic       r_jalr;

    logic       w_ir_load;
    logic       w_pc_load;
    logic       w_rf_wen;
    logic [1:0] w_pc_sel;
    logic       w_tmr_en;
    logic       w_tmr_clr;
    logic       w_tmr_done;
    logic       w_run;

    assign w_run     = !i_rst;
    assign w_tmr_en  = ((r_state == S_FETCH) && !i_imem_ack) ||
                       ((r_state == S_MEM)   && !i_dmem_ack);
    assign w_tmr_clr = (w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM));

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_tmr_clr),
        .i_enable (w_tmr_en),
        .o_done   (w_tmr_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_FETCH;
            r_cause <= CAUSE_NONE;
            r_load  <= 1'b0;
            r_we    <= 1'b0;
            r_lui   <= 1'b0;
            r_jal   <= 1'b0;
            r_jalr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC) begin
                r_load <= i_instype[IT_LOAD];
                r_we   <= i_wen;
                r_lui  <= i_instype[IT_LUI];
                r_jal  <= i_instype[IT_JAL];
                r_jalr <= i_instype[IT_JALR];
            end
            if ((r_state != S_TRAP) && (w_next == S_TRAP)) begin
                r_cause <= w_cause;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cause   = CAUSE_NONE;
        w_ir_load = 1'b0;
        w_pc_load = 1'b0;
        w_rf_wen  = 1'b0;
        w_pc_sel  = PC_SEQ;
        case (r_state)
            S_FETCH: begin
                // An ack in the final wait cycle still wins over the timeout.
                if (i_imem_ack) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end else if (w_tmr_done) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (!is_onehot(i_instype) || (i_ren && i_wen)) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_ILLEGAL;
                end else if (i_instype[IT_LOAD] || i_instype[IT_STORE]) begin
                    w_next = S_MEM;
                end else if (i_instype[IT_BRANCH]) begin
                    w_pc_load = 1'b1;
                    w_pc_sel  = i_br_taken ? PC_REL : PC_SEQ;
                    w_next    = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (i_dmem_ack) begin
                    if (r_load) begin
                        w_next = S_WB;
                    end else begin
                        w_pc_load = 1'b1;
                        w_next    = S_FETCH;
                    end
                end else if (w_tmr_done) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                w_rf_wen  = 1'b1;
                w_pc_load = 1'b1;
                if (r_jal) begin
                    w_pc_sel = PC_REL;
                end else if (r_jalr) begin
                    w_pc_sel = PC_REG;
                end
                w_next = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Reset parks the state in FETCH; gating keeps fetch request and strobes low while held.
    assign o_imem_req   = w_run && (r_state == S_FETCH);
    assign o_ir_load    = w_run && w_ir_load;
    assign o_pc_load    = w_run && w_pc_load;
    assign o_rf_wen     = w_run && w_rf_wen;
    assign o_pc_sel     = w_pc_sel;
    assign o_dmem_req   = (r_state == S_MEM);
    assign o_dmem_we    = (r_state == S_MEM) && r_we;
    assign o_trap       = (r_state == S_TRAP);
    assign o_trap_cause = r_cause;
    assign o_state      = r_state;

    // reg/imm/auipc fall through to the ALU result.
    always_comb begin
        o_wb_sel = WB_ALU;
        if (r_state == S_WB) begin
            if (r_load) begin
                o_wb_sel = WB_MEM;
            end else if (r_lui) begin
                o_wb_sel = WB_IMM;
            end else if (r_jal || r_jalr) begin
                o_wb_sel = WB_PC4;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - scoreboard testbench for ctrl_seq
import yarc_pkg::*;

module tb_ctrl_seq;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req, imem_ack, ir_load;
    logic [IT_W-1:0] instype = '0;
    logic            ren = 1'b0, wen = 1'b0, br_taken = 1'b0;
    logic            dmem_req, dmem_we, dmem_ack;
    logic            rf_wen, pc_load, trap;
    logic [1:0]      wb_sel, pc_sel, trap_cause;
    logic [2:0]      state;

    int iwait = -1, dwait = -1, icnt = 0, dcnt = 0;
    int total = 0, bad = 0;

    typedef struct {
        int trp; int cause; int psel; int wsel; int rf; int lat; int dreq; int we;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ctrl_seq #(.TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(imem_req), .i_imem_ack(imem_ack), .o_ir_load(ir_load),
        .i_instype(instype), .i_ren(ren), .i_wen(wen), .i_br_taken(br_taken),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_ack(dmem_ack),
        .o_rf_wen(rf_wen), .o_wb_sel(wb_sel), .o_pc_load(pc_load), .o_pc_sel(pc_sel),
        .o_trap(trap), .o_trap_cause(trap_cause), .o_state(state)
    );

    // Memory models: ack after a programmed number of wait cycles (-1 = never).
    assign imem_ack = imem_req && (icnt == iwait);
    assign dmem_ack = dmem_req && (dcnt == dwait);
    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [IT_W-1:0] cl(input int b);
        logic [IT_W-1:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // Called at posedge+1 with the DUT in its first FETCH cycle.
    task automatic run(input string tag, input logic [IT_W-1:0] cls, input logic r, w, b,
                       input int iw, dw, trp, cause, psel, wsel, nrf, lat, ndreq, we_exp);
        exp_t e, g;
        int cyc, nr, nd, lastwe;
        logic done, ok;
        e.trp = trp; e.cause = cause; e.psel = psel; e.wsel = wsel;
        e.rf = nrf; e.lat = lat; e.dreq = ndreq; e.we = we_exp;
        instype = cls; ren = r; wen = w; br_taken = b; iwait = iw; dwait = dw;
        sb.push_back(e);
        cyc = 0; nr = 0; nd = 0; lastwe = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rf_wen) nr++;
            if (dmem_req) begin nd++; lastwe = int'(dmem_we); end
            if (pc_load || trap) begin
                g = sb.pop_front();
                done = 1'b1;
                chk({tag, "_trap"}, trap, g.trp);
                chk({tag, "_lat"}, cyc, g.lat);
                chk({tag, "_rf"}, nr, g.rf);
                chk({tag, "_dreq"}, nd, g.dreq);
                if (g.dreq != 0) chk({tag, "_we"}, lastwe, g.we);
                if (g.trp != 0) begin
                    chk({tag, "_cause"}, trap_cause, g.cause);
                    ok = 1'b1;
                    repeat (20) begin
                        @(negedge clk);
                        if (!trap || trap_cause !== 2'(g.cause) || imem_req || dmem_req ||
                            dmem_we || ir_load || pc_load || rf_wen) ok = 1'b0;
                    end
                    chk({tag, "_hold"}, ok, 1);
                end else begin
                    chk({tag, "_psel"}, pc_sel, g.psel);
                    chk({tag, "_wsel"}, wb_sel, g.wsel);
                end
            end
        end
        if (!done) begin
            g = sb.pop_front();
            chk({tag, "_no_finish"}, 0, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_state", state, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_trap", trap, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_ir_load", ir_load, 0);
        do_reset();
        #1 chk("post_rst_imem_req", imem_req, 1);

        //   tag        class             r  w  b  iw  dw  trp c ps ws rf lat dreq we
        run("reg",    cl(IT_REG),      0, 0, 0,  0,  0, 0, 0, 0, 0, 1, 4,  0, 0);
        run("imm",    cl(IT_IMM),      0, 0, 0,  0,  0, 0, 0, 0, 0, 1, 4,  0, 0);
        run("auipc",  cl(IT_AUIPC),    0, 0, 0,  0,  0, 0, 0, 0, 0, 1, 4,  0, 0);
        run("lui",    cl(IT_LUI),      0, 0, 0,  0,  0, 0, 0, 0, 3, 1, 4,  0, 0);
        run("jal",    cl(IT_JAL),      0, 0, 0,  0,  0, 0, 0, 1, 2, 1, 4,  0, 0);
        run("jalr",   cl(IT_JALR),     0, 0, 0,  0,  0, 0, 0, 2, 2, 1, 4,  0, 0);
        run("br_t",   cl(IT_BRANCH),   0, 0, 1,  0,  0, 0, 0, 1, 0, 0, 3,  0, 0);
        run("br_nt",  cl(IT_BRANCH),   0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 3,  0, 0);
        run("store",  cl(IT_STORE),    0, 1, 0,  0,  0, 0, 0, 0, 0, 0, 4,  1, 1);
        run("load0",  cl(IT_LOAD),     1, 0, 0,  0,  0, 0, 0, 0, 1, 1, 5,  1, 0);
        run("load3",  cl(IT_LOAD),     1, 0, 0,  0,  3, 0, 0, 0, 1, 1, 8,  4, 0);
        run("st_w2",  cl(IT_STORE),    0, 1, 0,  2,  2, 0, 0, 0, 0, 0, 8,  3, 1);
        run("if_edge",cl(IT_REG),      0, 0, 0, 14,  0, 0, 0, 0, 0, 1, 18, 0, 0);
        run("dm_edge",cl(IT_LOAD),     1, 0, 0,  0, 14, 0, 0, 0, 1, 1, 19, 15, 0);

        run("ill_two",9'b000000011,    0, 0, 0,  0,  0, 1, 1, 0, 0, 0, 4,  0, 0);
        do_reset();
        chk("trap_clear", trap, 0);
        chk("cause_clear", trap_cause, 0);
        run("ill_zero",9'b000000000,   0, 0, 0,  0,  0, 1, 1, 0, 0, 0, 4,  0, 0);
        do_reset();
        run("ill_rw", cl(IT_LOAD),     1, 1, 0,  0,  0, 1, 1, 0, 0, 0, 4,  0, 0);
        do_reset();
        run("if_to",  cl(IT_REG),      0, 0, 0, -1,  0, 1, 2, 0, 0, 0, 16, 0, 0);
        do_reset();
        run("dm_to",  cl(IT_LOAD),     1, 0, 0,  0, -1, 1, 2, 0, 0, 0, 19, 15, 0);
        do_reset();

        // Reset asserted mid data wait.
        instype = cl(IT_LOAD); ren = 1'b1; wen = 1'b0; iwait = 0; dwait = -1;
        repeat (5) @(posedge clk);
        #3;
        chk("mid_state", state, 3);
        chk("mid_dreq", dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_dreq_async", dmem_req, 0);
        chk("rst_state_async", state, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rel_imem_req", imem_req, 1);
        run("post_mid",cl(IT_REG),     0, 0, 0, 14,  0, 0, 0, 0, 0, 1, 18, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
